// File: rtl/inst_fetch_ctrl_if.sv
// Memory-side read bus between the fetch controller (master) and instruction memory (slave).
// One request outstanding at a time; ack is a single-cycle data-valid pulse.
interface inst_fetch_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one-word hold buffer in front of a request/ack memory,
// stalling the CPU on a miss and substituting NOP_INST when memory fails to answer in time.
module inst_fetch_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rom_ce_i,
    input  logic [31:0]               rom_addr_i,
    output logic [31:0]               rom_data_o,
    output logic                      stall_req_o,
    input  logic                      invalidate_i,
    output logic                      fetch_err_o,
    inst_fetch_ctrl_if.master         mem
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {StIdle, StReq} state_e;

    state_e      state_q, state_d;
    logic        valid_q, valid_d;
    logic [29:0] tag_q, tag_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        fetch_err_q, fetch_err_d;
    logic        hit;

    assign hit         = rom_ce_i & valid_q & (tag_q == rom_addr_i[31:2]);
    assign rom_data_o  = hit ? data_q : 32'h0;
    assign stall_req_o = rom_ce_i & ~hit;
    assign fetch_err_o = fetch_err_q;
    assign mem.req     = mem_req_q;
    assign mem.addr    = mem_addr_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        fetch_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (invalidate_i) begin
                    valid_d = 1'b0;
                end
                if (rom_ce_i && !hit) begin
                    state_d    = StReq;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {rom_addr_i[31:2], 2'b00};
                    cnt_d      = 8'd0;
                end
            end
            StReq: begin
                // Ack beats timeout; an invalidate coinciding with the fill suppresses only that fill.
                if (mem.ack) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    tag_d     = mem_addr_q[31:2];
                    data_d    = mem.data;
                    valid_d   = ~invalidate_i;
                end else if (cnt_q == CntLast) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    tag_d       = mem_addr_q[31:2];
                    data_d      = NOP_INST;
                    valid_d     = 1'b1;
                    fetch_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            tag_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fetch_err_q <= fetch_err_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the hold buffer and memory request.
module tb_inst_fetch_ctrl;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        rom_ce   = 1'b0;
    logic [31:0] rom_addr = 32'h0;
    logic        inv      = 1'b0;
    logic [31:0] rom_data;
    logic        stall;
    logic        ferr;

    int errors = 0;
    int checks = 0;

    inst_fetch_ctrl_if mem_if ();

    inst_fetch_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .NOP_INST       (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_ce_i     (rom_ce),
        .rom_addr_i   (rom_addr),
        .rom_data_o   (rom_data),
        .stall_req_o  (stall),
        .invalidate_i (inv),
        .fetch_err_o  (ferr),
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: buffer contents plus at most one outstanding request, timed by absolute cycle number.
    bit          m_valid = 1'b0;
    logic [29:0] m_tag   = '0;
    logic [31:0] m_data  = '0;
    bit          m_busy  = 1'b0;
    logic [31:0] m_addr  = '0;
    bit          m_err   = 1'b0;
    int          m_start = 0;
    int          cyc     = 0;
    bit          e_hit;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            m_valid = 1'b0; m_tag = '0; m_data = '0;
            m_busy  = 1'b0; m_addr = '0; m_err = 1'b0;
        end
        e_hit = rom_ce && m_valid && (m_tag == rom_addr[31:2]);
        chk("rom_data", rom_data, e_hit ? m_data : 32'h0);
        chk("stall", {31'b0, stall}, {31'b0, rom_ce && !e_hit});
        chk("mem_req", {31'b0, mem_if.req}, {31'b0, m_busy});
        chk("fetch_err", {31'b0, ferr}, {31'b0, m_err});
        if (m_busy) chk("mem_addr", mem_if.addr, m_addr);
        if (rst_n) begin
            m_err = 1'b0;
            if (m_busy) begin
                if (mem_if.ack) begin
                    m_tag = m_addr[31:2]; m_data = mem_if.data; m_valid = !inv; m_busy = 1'b0;
                end else if (cyc == m_start + int'(TO)) begin
                    m_tag = m_addr[31:2]; m_data = NOP; m_valid = 1'b1; m_busy = 1'b0;
                    m_err = 1'b1;
                end
            end else begin
                if (inv) m_valid = 1'b0;
                if (rom_ce && !e_hit) begin
                    m_busy = 1'b1; m_addr = {rom_addr[31:2], 2'b00}; m_start = cyc;
                end
            end
            cyc++;
        end
    end

    // Inputs change on the falling edge; returns 3 time units later for literal checks.
    task automatic drive(input bit ce, input logic [31:0] a, input bit i, input bit ack,
                         input logic [31:0] d);
        @(negedge clk);
        rom_ce = ce; rom_addr = a; inv = i; mem_if.ack = ack; mem_if.data = d;
        #3;
    endtask

    initial begin
        mem_if.ack  = 1'b0;
        mem_if.data = 32'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst mem_req", {31'b0, mem_if.req}, 32'h0);
        chk("rst mem_addr", mem_if.addr, 32'h0);
        chk("rst fetch_err", {31'b0, ferr}, 32'h0);
        chk("rst rom_data", rom_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Miss with ack in first REQ cycle
        drive(1, 32'h4, 0, 0, 0);
        chk("miss stall c1", {31'b0, stall}, 32'h1);
        drive(1, 32'h4, 0, 1, 32'h3401_1100);
        chk("miss stall c2", {31'b0, stall}, 32'h1);
        chk("miss mem_addr", mem_if.addr, 32'h4);
        drive(1, 32'h4, 0, 0, 0);
        chk("miss done stall", {31'b0, stall}, 32'h0);
        chk("miss done data", rom_data, 32'h3401_1100);
        // Hit, low address bits ignored
        drive(1, 32'h6, 0, 0, 0);
        chk("hit stall", {31'b0, stall}, 32'h0);
        chk("hit data", rom_data, 32'h3401_1100);
        chk("hit mem_req", {31'b0, mem_if.req}, 32'h0);

        // Timeout
        drive(1, 32'h100, 0, 0, 0);
        for (int k = 0; k < int'(TO); k++) begin
            drive(1, 32'h100, 0, 0, 0);
            chk("to mem_req", {31'b0, mem_if.req}, 32'h1);
            chk("to no err", {31'b0, ferr}, 32'h0);
        end
        drive(1, 32'h100, 0, 0, 0);
        chk("to err", {31'b0, ferr}, 32'h1);
        chk("to data", rom_data, 32'h0);
        chk("to stall", {31'b0, stall}, 32'h0);
        chk("to req off", {31'b0, mem_if.req}, 32'h0);
        drive(1, 32'h100, 0, 0, 0);
        chk("to err pulse", {31'b0, ferr}, 32'h0);

        // Address change while a fetch is in flight
        drive(1, 32'h8, 0, 0, 0);
        drive(1, 32'hC, 0, 0, 0);
        chk("chg mem_addr", mem_if.addr, 32'h8);
        drive(1, 32'hC, 0, 1, 32'hAAAA_0000);
        drive(1, 32'h8, 0, 0, 0);
        chk("chg tag 8 hit", rom_data, 32'hAAAA_0000);
        drive(1, 32'hC, 0, 0, 0);
        chk("chg C miss", {31'b0, stall}, 32'h1);
        drive(1, 32'hC, 0, 0, 0);
        chk("chg C req", {31'b0, mem_if.req}, 32'h1);
        chk("chg C addr", mem_if.addr, 32'hC);
        drive(1, 32'hC, 0, 1, 32'h1234_5678);
        drive(1, 32'hC, 0, 0, 0);
        chk("chg C data", rom_data, 32'h1234_5678);

        // Invalidate coincident with ack
        drive(1, 32'h20, 0, 0, 0);
        drive(1, 32'h20, 1, 1, 32'hDEAD_0000);
        chk("inv req", {31'b0, mem_if.req}, 32'h1);
        drive(1, 32'h20, 0, 0, 0);
        chk("inv miss", {31'b0, stall}, 32'h1);
        drive(1, 32'h20, 0, 0, 0);
        chk("inv refetch", mem_if.addr, 32'h20);
        drive(1, 32'h20, 0, 1, 32'h0BAD_F00D);
        drive(1, 32'h20, 0, 0, 0);
        chk("inv refill", rom_data, 32'h0BAD_F00D);

        // Async reset mid-REQ, late ack after release
        drive(1, 32'h40, 0, 0, 0);
        repeat (3) drive(1, 32'h40, 0, 0, 0);
        #1 rst_n = 1'b0;
        #0.5;
        chk("arst mem_req", {31'b0, mem_if.req}, 32'h0);
        chk("arst mem_addr", mem_if.addr, 32'h0);
        chk("arst data", rom_data, 32'h0);
        chk("arst stall", {31'b0, stall}, 32'h1);
        drive(1, 32'h40, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_if.ack = 1'b1; mem_if.data = 32'hFEED_FACE;
        #3;
        chk("late ack stall", {31'b0, stall}, 32'h1);
        drive(1, 32'h40, 0, 0, 0);
        chk("late ack req", {31'b0, mem_if.req}, 32'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a = (($urandom % 16) == 0) ? ($urandom & 32'hFFFF_FF00) : 32'h0;
            a = a | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            drive(($urandom % 8) != 0, a, ($urandom % 20) == 0, ($urandom % 3) == 0, $urandom);
        end
        drive(0, 32'h0, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
